mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single memory port of the `verilog_riscv` core between instruction fetch (IF) and data load/store (DM). Each requester gets a request/acknowledge handshake. A registered FSM serialises transactions onto one variable-latency memory port. Round-robin ordering applies under contention, and a watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin IF/DM arbiter serialising transactions onto a single
//            variable-latency memory port, with an optional ack watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // instruction fetch requester
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_ack,
  output logic [DATA_W-1:0]     o_if_rdata,
  output logic                  o_if_err,
  // data load/store requester
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_W-1:0]     i_dm_addr,
  input  logic [DATA_W-1:0]     i_dm_wdata,
  input  logic [DATA_W/8-1:0]   i_dm_be,
  output logic                  o_dm_ack,
  output logic [DATA_W-1:0]     o_dm_rdata,
  output logic                  o_dm_err,
  // shared memory port
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_be,
  input  logic                  i_mem_ack,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_busy
);

  localparam int c_BE_W  = DATA_W / 8;
  localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

  localparam logic c_OWN_IF = 1'b0;
  localparam logic c_OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state,     w_state_nx;
  logic                r_owner,     w_owner_nx;
  logic                r_last,      w_last_nx;
  logic [c_CNT_W-1:0]  r_cnt,       w_cnt_nx;

  logic                r_mem_req,   w_mem_req_nx;
  logic                r_mem_we,    w_mem_we_nx;
  logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nx;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nx;
  logic [c_BE_W-1:0]   r_mem_be,    w_mem_be_nx;

  logic                r_if_ack,    w_if_ack_nx;
  logic [DATA_W-1:0]   r_if_rdata,  w_if_rdata_nx;
  logic                r_if_err,    w_if_err_nx;
  logic                r_dm_ack,    w_dm_ack_nx;
  logic [DATA_W-1:0]   r_dm_rdata,  w_dm_rdata_nx;
  logic                r_dm_err,    w_dm_err_nx;

  logic                w_grant_any;
  logic                w_grant_dm;
  logic                w_tmo_hit;
  logic                w_finish;
  logic [DATA_W-1:0]   w_resp_data;
  logic                w_resp_err;

  // On a tie the requester that did not win last time gets the port.
  assign w_grant_any = i_if_req | i_dm_req;
  assign w_grant_dm  = i_dm_req & (~i_if_req | (r_last == c_OWN_IF));
  assign w_tmo_hit   = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_nx     = r_state;
    w_owner_nx     = r_owner;
    w_last_nx      = r_last;
    w_cnt_nx       = r_cnt;
    w_mem_req_nx   = r_mem_req;
    w_mem_we_nx    = r_mem_we;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_mem_be_nx    = r_mem_be;
    w_if_ack_nx    = 1'b0;
    w_if_rdata_nx  = r_if_rdata;
    w_if_err_nx    = r_if_err;
    w_dm_ack_nx    = 1'b0;
    w_dm_rdata_nx  = r_dm_rdata;
    w_dm_err_nx    = r_dm_err;
    w_finish       = 1'b0;
    w_resp_data    = '0;
    w_resp_err     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_state_nx   = S_BUSY;
          w_owner_nx   = w_grant_dm;
          w_last_nx    = w_grant_dm;
          w_cnt_nx     = '0;
          w_mem_req_nx = 1'b1;
          if (w_grant_dm) begin
            w_mem_we_nx    = i_dm_we;
            w_mem_addr_nx  = i_dm_addr;
            w_mem_wdata_nx = i_dm_wdata;
            w_mem_be_nx    = i_dm_be;
          end else begin
            w_mem_we_nx    = 1'b0;
            w_mem_addr_nx  = i_if_addr;
            w_mem_wdata_nx = '0;
            w_mem_be_nx    = '1;
          end
        end
      end

      S_BUSY: begin
        if (r_cnt != c_CNT_MAX) begin
          w_cnt_nx = r_cnt + c_CNT_ONE;
        end
        // A real ack wins over a watchdog expiry in the same cycle.
        if (i_mem_ack) begin
          w_finish    = 1'b1;
          w_resp_data = r_mem_we ? '0 : i_mem_rdata;
        end else if (w_tmo_hit) begin
          w_finish   = 1'b1;
          w_resp_err = 1'b1;
        end
      end

      S_RESP: begin
        w_state_nx = S_IDLE;
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_finish) begin
      w_state_nx   = S_RESP;
      w_mem_req_nx = 1'b0;
      if (r_owner == c_OWN_DM) begin
        w_dm_ack_nx   = 1'b1;
        w_dm_rdata_nx = w_resp_data;
        w_dm_err_nx   = w_resp_err;
      end else begin
        w_if_ack_nx   = 1'b1;
        w_if_rdata_nx = w_resp_data;
        w_if_err_nx   = w_resp_err;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= c_OWN_IF;
      r_last      <= c_OWN_DM;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_dm_rdata  <= '0;
      r_dm_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_owner     <= w_owner_nx;
      r_last      <= w_last_nx;
      r_cnt       <= w_cnt_nx;
      r_mem_req   <= w_mem_req_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_mem_be    <= w_mem_be_nx;
      r_if_ack    <= w_if_ack_nx;
      r_if_rdata  <= w_if_rdata_nx;
      r_if_err    <= w_if_err_nx;
      r_dm_ack    <= w_dm_ack_nx;
      r_dm_rdata  <= w_dm_rdata_nx;
      r_dm_err    <= w_dm_err_nx;
    end
  end

  assign o_if_ack    = r_if_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_if_err    = r_if_err;
  assign o_dm_ack    = r_dm_ack;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_dm_err    = r_dm_err;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter with a transaction-level
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [BW-1:0] dm_be = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          dm_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ack(if_ack), .o_if_rdata(if_rdata), .o_if_err(if_err),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_be(dm_be),
    .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata), .o_dm_err(dm_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Memory: acks after mem_lat wait cycles (-1 = never); mem_force holds ack high.
  int            mem_lat   = 0;
  int            mem_cnt   = 0;
  logic          mem_ack_r = 1'b0;
  logic          mem_force = 1'b0;
  logic [DW-1:0] mem_data  = '0;
  assign mem_ack   = mem_ack_r | mem_force;
  assign mem_rdata = mem_data;

  always @(negedge clk) begin
    if (mem_req && !mem_ack_r) begin
      mem_ack_r <= (mem_lat >= 0) && (mem_cnt == mem_lat);
      mem_cnt   <= mem_cnt + 1;
    end else begin
      mem_ack_r <= 1'b0;
      mem_cnt   <= 0;
    end
  end

  // Reference model: a transaction is pending, waiting, or being answered.
  logic          m_active, m_resp, m_owner_dm, m_last_dm;
  int            m_waited;
  logic          e_mem_req, e_mem_we;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata;
  logic [BW-1:0] e_mem_be;
  logic          e_if_ack, e_if_err, e_dm_ack, e_dm_err;
  logic [DW-1:0] e_if_rdata, e_dm_rdata;

  logic          v_dm_wins, v_tmo;
  logic [DW-1:0] v_ack_data;
  assign v_dm_wins  = dm_req && (!if_req || !m_last_dm);
  assign v_tmo      = (TMO != 0) && (m_waited + 1 >= TMO);
  assign v_ack_data = e_mem_we ? '0 : mem_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_resp <= 1'b0; m_owner_dm <= 1'b0; m_last_dm <= 1'b1;
      m_waited <= 0;
      e_mem_req <= 1'b0; e_mem_we <= 1'b0; e_mem_addr <= '0; e_mem_wdata <= '0; e_mem_be <= '0;
      e_if_ack <= 1'b0; e_if_rdata <= '0; e_if_err <= 1'b0;
      e_dm_ack <= 1'b0; e_dm_rdata <= '0; e_dm_err <= 1'b0;
    end else begin
      e_if_ack <= 1'b0;
      e_dm_ack <= 1'b0;
      if (m_resp) begin
        m_resp <= 1'b0;
      end else if (m_active) begin
        m_waited <= m_waited + 1;
        if (mem_ack || v_tmo) begin
          m_active  <= 1'b0;
          m_resp    <= 1'b1;
          e_mem_req <= 1'b0;
          if (m_owner_dm) begin
            e_dm_ack   <= 1'b1;
            e_dm_rdata <= mem_ack ? v_ack_data : '0;
            e_dm_err   <= !mem_ack;
          end else begin
            e_if_ack   <= 1'b1;
            e_if_rdata <= mem_ack ? v_ack_data : '0;
            e_if_err   <= !mem_ack;
          end
        end
      end else if (if_req || dm_req) begin
        m_active    <= 1'b1;
        m_waited    <= 0;
        m_owner_dm  <= v_dm_wins;
        m_last_dm   <= v_dm_wins;
        e_mem_req   <= 1'b1;
        e_mem_we    <= v_dm_wins ? dm_we : 1'b0;
        e_mem_addr  <= v_dm_wins ? dm_addr : if_addr;
        e_mem_wdata <= v_dm_wins ? dm_wdata : '0;
        e_mem_be    <= v_dm_wins ? dm_be : '1;
      end
    end
  end

  typedef struct {int cyc; bit who;} ev_t;
  ev_t ack_q[$];
  int  ack_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {busy, mem_req, mem_we, if_ack, dm_ack, if_err, dm_err,
                            |mem_addr, |mem_wdata, |mem_be, |if_rdata, |dm_rdata}, '0);
    end else begin
      chk("busy", busy, m_active | m_resp);
      chk("mem_req", mem_req, e_mem_req);
      if (e_mem_req) begin
        chk("mem_we", mem_we, e_mem_we);
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("mem_be", mem_be, e_mem_be);
      end
      chk("if_ack", if_ack, e_if_ack);
      chk("dm_ack", dm_ack, e_dm_ack);
      if (e_if_ack) begin
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("if_err", if_err, e_if_err);
      end
      if (e_dm_ack) begin
        chk("dm_rdata", dm_rdata, e_dm_rdata);
        chk("dm_err", dm_err, e_dm_err);
      end
      if (if_ack) ack_q.push_back('{cyc, 1'b0});
      if (dm_ack) ack_q.push_back('{cyc, 1'b1});
      if (if_ack || dm_ack) ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit dm, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (dm ? dm_ack : if_ack) got = 1'b1;
    end
    chk("wait_ack", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int n_ack;
    bit got;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single fetch, zero-latency memory
    step();
    mem_lat = 0; mem_data = 32'hDEADBEEF; if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    step();
    chk("t1_if_ack", if_ack, 1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    step();
    chk("t1_busy", busy, 0);

    // Store with 3 wait states (ack in 4th request cycle)
    n_ack = ack_cnt;
    mem_lat = 3; mem_data = 32'hAAAA5555;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678; dm_be = 4'h3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_mem_req", mem_req, 1);
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_addr", mem_addr, 32'h200);
      chk("t2_mem_wdata", mem_wdata, 32'h12345678);
      chk("t2_mem_be", mem_be, 4'h3);
    end
    step();
    chk("t2_dm_ack", dm_ack, 1);
    chk("t2_dm_rdata", dm_rdata, 0);
    chk("t2_if_ack", if_ack, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    chk("t2_ack_count", ack_cnt, n_ack + 1);

    // Contention from reset: IF, DM, IF, DM, three cycles apart
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    ack_q.delete();
    mem_lat = 0; mem_data = 32'h00001111;
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_be = 4'hF;
    repeat (11) step();
    if_req = 1'b0; dm_req = 1'b0;
    step();
    chk("t3_n_acks", ack_q.size(), 4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++) begin
      chk("t3_order", ack_q[i].who, i % 2);
      chk("t3_ack_cycle", ack_q[i].cyc - t0, 2 + 3 * i);
    end

    // Watchdog: memory never acknowledges a DM load
    step();
    mem_lat = -1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    for (int i = 0; i < TMO; i++) begin
      step();
      chk("t4_mem_req_on", mem_req, 1);
    end
    step();
    chk("t4_mem_req_off", mem_req, 0);
    chk("t4_dm_ack", dm_ack, 1);
    chk("t4_dm_err", dm_err, 1);
    chk("t4_dm_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    step();
    mem_lat = 1; mem_data = 32'hCAFEF00D; if_req = 1'b1; if_addr = 32'h600;
    wait_ack(1'b0, 20, got);
    chk("t4_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("t4_if_err", if_err, 0);
    if_req = 1'b0;

    // Reset during the third wait cycle of an IF load
    step(); step();
    mem_lat = -1; if_req = 1'b1; if_addr = 32'h700;
    step(); step();
    @(posedge clk);
    #3;
    chk("t5_busy_before", busy, 1);
    chk("t5_mem_req_before", mem_req, 1);
    n_ack = ack_cnt;
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_mem_req", mem_req, 0);
    chk("t5_rst_fields", {mem_we, |mem_addr, |mem_wdata, |mem_be}, 0);
    chk("t5_rst_resp", {if_ack, dm_ack, if_err, dm_err, |if_rdata, |dm_rdata}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("t5_no_ack", ack_cnt, n_ack);
    mem_lat = 2; mem_data = 32'h0BADF00D;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800; dm_be = 4'hF;
    wait_ack(1'b1, 20, got);
    chk("t5_dm_rdata", dm_rdata, 32'h0BADF00D);
    chk("t5_dm_err", dm_err, 0);
    dm_req = 1'b0;

    // Memory ack held high through IDLE and RESP
    step();
    n_ack = ack_cnt;
    mem_force = 1'b1;
    repeat (3) begin
      step();
      chk("t6_idle_busy", busy, 0);
    end
    if_req = 1'b1; if_addr = 32'h900; mem_data = 32'h13579BDF;
    step();
    chk("t6_mem_req", mem_req, 1);
    step();
    chk("t6_if_ack", if_ack, 1);
    chk("t6_if_rdata", if_rdata, 32'h13579BDF);
    if_req = 1'b0;
    step();
    chk("t6_after_resp_busy", busy, 0);
    chk("t6_after_resp_ack", if_ack, 0);
    step();
    chk("t6_still_idle", busy, 0);
    mem_force = 1'b0;
    step();
    chk("t6_ack_count", ack_cnt, n_ack + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
